serdes_rx_deser: RTL
====================

Name: serdes_rx_deser

Overview:
Input-side deserializer placed after an IBUF/IBUFDS pad buffer. It is the receive counterpart of the OSERDES-driven OBUFDS output path.
- Shifts in a serial bitstream, MSB first, one bit per enabled clock.
- Emits a parallel word every DATA_WIDTH bits.
- Supports manual bitslip and automatic word alignment against a training pattern.
- Synthesisable fabric model for targets and flows that do not use the hard ISERDES.

Parameters:
DATA_WIDTH, 8, deserialization ratio and word width; legal range 2..16.
TRAIN_PATTERN, 8'hB5, expected training word, DATA_WIDTH bits wide; must not equal any of its own non-trivial rotations.
LOCK_COUNT, 4, consecutive matching words required to declare lock; legal range 1..15.

Ports:
CLK  input  1  sampling clock; all state on rising edge.
RST_N  input  1  asynchronous active-low reset.
CE  input  1  bit enable; D is sampled only when CE=1.
D  input  1  serial data from pad buffer.
BITSLIP  input  1  manual slip request; honoured only in IDLE.
TRAIN  input  1  1 = run automatic alignment.
Q  output  DATA_WIDTH  last completed word; first received bit in Q[DATA_WIDTH-1].
Q_VALID  output  1  one-cycle pulse when Q updates.
LOCKED  output  1  alignment achieved.
SLIP_CNT  output  4  total slips applied, modulo DATA_WIDTH.

Behaviour:
- Reset: RST_N low asynchronously clears all state.
  - Outputs: Q=0, Q_VALID=0, LOCKED=0, SLIP_CNT=0.
  - Internal: shift register=0, bit counter=0, FSM=IDLE, match counter=0, pending slip=0.
  - Reset asserted mid-word or mid-HUNT discards everything.
- slip_now = CE & (manual_slip | pending_slip), where manual_slip = BITSLIP & (state==IDLE).
- Shift:
  - If CE & !slip_now: sr <= {sr[W-2:0], D} and cnt increments.
  - If slip_now: the bit on D is dropped, sr and cnt hold, SLIP_CNT <= (SLIP_CNT+1) mod DATA_WIDTH, pending_slip clears.
  - CE=0 freezes sr, cnt and the FSM; Q_VALID is 0 on those cycles.
- Word completion: CE & !slip_now & cnt==W-1.
  - Next edge: Q <= {sr[W-2:0], D}, Q_VALID=1 for exactly one cycle, cnt <= 0.
  - Latency is 1 cycle from the last bit sampled to Q_VALID.
- Comparison uses the completing word value w = {sr[W-2:0], D} in the completion cycle.
- FSM states:
  - IDLE: LOCKED holds its last value. TRAIN=1 -> HUNT, with LOCKED<=0 and match counter<=0.
  - HUNT:
    - On completion with w==TRAIN_PATTERN: match counter +1. When it reaches LOCK_COUNT -> LOCKED state, LOCKED<=1.
    - On completion with w!=TRAIN_PATTERN: pending_slip<=1, match counter<=0 -> SETTLE.
  - SETTLE: the next completed word is ignored (it straddles the slip), then -> HUNT.
  - LOCKED: LOCKED=1. Word contents are ignored, since user data follows training.
  - TRAIN=0 from any state -> IDLE at the next edge; LOCKED is retained.
  - TRAIN re-asserted from IDLE restarts HUNT.
- Q and Q_VALID keep updating in every state, including SETTLE.
- Boundary cases:
  - Manual BITSLIP outside IDLE is ignored.
  - BITSLIP held high slips once per CE cycle.
  - No timeout in HUNT; it slips indefinitely until lock.
  - A pending slip waits across CE=0 cycles.

Test Plan:
- Reset check: assert RST_N=0 mid-stream with no clock edge -> Q=0, Q_VALID=0, LOCKED=0, SLIP_CNT=0 immediately.
- Plain deserialization: TRAIN=0, CE=1, serial 8'hA5 then 8'h3C MSB first starting the first cycle after reset -> Q_VALID pulses on cycles 8 and 16, Q=8'hA5 then 8'h3C.
- Manual slip: one-cycle BITSLIP during bit 3 of a stream of 8'hA5 words -> that bit is dropped, SLIP_CNT=1, following words are the rotated 8'h4B... sequence with the boundary delayed 1 bit.
- Auto-align: TRAIN=1, stream of 3'b000 then repeating 8'hB5 -> exactly 3 slips (SLIP_CNT=3), then 4 consecutive 8'hB5 words, then LOCKED=1.
- CE gaps: the same stream as the plain-deserialization case with CE=0 on every other cycle -> identical Q sequence, with Q_VALID spacing of 16 cycles.
- Retrain: lock, drop TRAIN (LOCKED stays 1), re-raise TRAIN -> LOCKED=0 the next cycle, then relock after 4 8'hB5 words with no new slips.

Source files
------------

// File: rtl/serdes_rx_deser.sv
// serdes_rx_deser: fabric deserializer with manual bitslip and training-pattern word alignment
// Ports:
//   clk      sampling clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   ce       bit enable; d is sampled only when high
//   d        serial data from the pad buffer, MSB first
//   bitslip  manual slip request, honoured only in IDLE
//   train    high runs automatic alignment against TRAIN_PATTERN
//   q        last completed word, first received bit in q[DATA_WIDTH-1]
//   q_valid  one-cycle pulse when q updates
//   locked   alignment achieved
//   slip_cnt total slips applied, modulo DATA_WIDTH
module serdes_rx_deser #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'hB5),
    parameter int                    LOCK_COUNT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  d,
    input  logic                  bitslip,
    input  logic                  train,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  locked,
    output logic [3:0]            slip_cnt
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, HUNT, SETTLE, LOCK} state_t;
    state_t       state, state_nx;
    logic [W-2:0] sr;
    logic [W-1:0] w;
    logic [3:0]   cnt, mcnt, mcnt_nx;
    logic         pend, pend_nx, locked_nx;
    logic         slip_now, shift_en, done, match, last_match;
    // w is the word as it would stand after this bit is shifted in
    assign w          = {sr, d};
    assign slip_now   = ce & ((bitslip & (state == IDLE)) | pend);
    assign shift_en   = ce & ~slip_now;
    assign done       = shift_en & (cnt == 4'(W-1));
    assign match      = w == TRAIN_PATTERN;
    assign last_match = mcnt == 4'(LOCK_COUNT-1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (ce) begin
            if (!train) state_nx = IDLE;
            else case (state)
                IDLE:    state_nx = HUNT;
                HUNT:    state_nx = !done ? HUNT : !match ? SETTLE : last_match ? LOCK : HUNT;
                SETTLE:  state_nx = done ? HUNT : SETTLE;
                default: state_nx = LOCK;
            endcase
        end
    end
    // the word completing in SETTLE straddles the slip, so only HUNT judges words
    always_comb begin
        locked_nx = locked;
        mcnt_nx   = mcnt;
        pend_nx   = pend & ~slip_now;
        if (ce && train) begin
            if (state == IDLE) begin
                locked_nx = 1'b0;
                mcnt_nx   = '0;
            end else if (state == HUNT && done) begin
                mcnt_nx   = match ? mcnt + 4'd1 : '0;
                locked_nx = match & last_match;
                pend_nx   = ~match;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
            slip_cnt <= '0;
            locked   <= 1'b0;
            mcnt     <= '0;
            pend     <= 1'b0;
        end else begin
            q_valid <= done;
            if (shift_en) begin
                sr  <= w[W-2:0];
                cnt <= done ? '0 : cnt + 4'd1;
            end
            if (done) q <= w;
            if (slip_now) slip_cnt <= (slip_cnt == 4'(W-1)) ? '0 : slip_cnt + 4'd1;
            locked <= locked_nx;
            mcnt   <= mcnt_nx;
            pend   <= pend_nx;
        end
    end
endmodule
